// File: rtl/gpu_sprite_pkg.sv
// Shared sprite-controller definitions: command codes, request kinds, field widths,
// the latched request record and the sequencer state encoding.
// Used by the command sequencer, its encoder and the sprite controllers.
package gpu_sprite_pkg;

  localparam int ADDR_W  = 23;
  localparam int POS_W   = 11;
  localparam int DIM_W   = 10;
  localparam int INSTR_W = 4;
  localparam int KIND_W  = 2;
  localparam int STEP_W  = 3;

  // Instruction codes decoded by the sprite controllers
  localparam logic [INSTR_W-1:0] SET_SPRITE   = 4'd1;
  localparam logic [INSTR_W-1:0] SET_X        = 4'd2;
  localparam logic [INSTR_W-1:0] SET_Y        = 4'd3;
  localparam logic [INSTR_W-1:0] SET_WIDTH    = 4'd4;
  localparam logic [INSTR_W-1:0] SET_HEIGHT   = 4'd5;
  localparam logic [INSTR_W-1:0] SHIFT_X      = 4'd6;
  localparam logic [INSTR_W-1:0] SHIFT_Y      = 4'd7;
  localparam logic [INSTR_W-1:0] CLEAR_SPRITE = 4'd8;
  localparam logic [INSTR_W-1:0] SET_VISIBLE  = 4'd9;

  // High-level request kinds
  localparam logic [KIND_W-1:0] KIND_DEFINE = 2'd0;
  localparam logic [KIND_W-1:0] KIND_MOVE   = 2'd1;
  localparam logic [KIND_W-1:0] KIND_HIDE   = 2'd2;
  localparam logic [KIND_W-1:0] KIND_SHOW   = 2'd3;

  typedef struct packed {
    logic [KIND_W-1:0]       kind;
    logic [ADDR_W-1:0]       addr;
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic [DIM_W-1:0]        width;
    logic [DIM_W-1:0]        height;
  } sprite_req_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_VBLANK = 2'd1,
    ST_ISSUE       = 2'd2
  } seq_state_t;

  // Number of controller writes a request expands into; a move skips zero deltas.
  function automatic logic [STEP_W-1:0] write_count(input sprite_req_t req);
    logic [STEP_W-1:0] n;
    case (req.kind)
      KIND_DEFINE: n = STEP_W'(5);
      KIND_MOVE:   n = STEP_W'(req.x != '0) + STEP_W'(req.y != '0);
      default:     n = STEP_W'(1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sprite_cmd_encode.sv
// Maps (latched request, step index) to the controller instruction and payload.
// Ports: i_req latched request, i_step write index within the request,
//        o_instruction / o_data the command for that step. Purely combinational.
module sprite_cmd_encode
  import gpu_sprite_pkg::*;
(
  input  sprite_req_t        i_req,
  input  logic [STEP_W-1:0]  i_step,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [ADDR_W-1:0]  o_data
);

  always_comb begin
    o_instruction = '0;
    o_data        = '0;
    case (i_req.kind)
      KIND_DEFINE: begin
        // Geometry first, set-sprite last so the sprite appears with final geometry
        case (i_step)
          STEP_W'(0): begin
            o_instruction = SET_WIDTH;
            o_data        = {{(ADDR_W-DIM_W){1'b0}}, i_req.width};
          end
          STEP_W'(1): begin
            o_instruction = SET_HEIGHT;
            o_data        = {{(ADDR_W-DIM_W){1'b0}}, i_req.height};
          end
          STEP_W'(2): begin
            o_instruction = SET_X;
            o_data        = {{(ADDR_W-POS_W){1'b0}}, i_req.x};
          end
          STEP_W'(3): begin
            o_instruction = SET_Y;
            o_data        = {{(ADDR_W-POS_W){1'b0}}, i_req.y};
          end
          default: begin
            o_instruction = SET_SPRITE;
            o_data        = i_req.addr;
          end
        endcase
      end
      KIND_MOVE: begin
        // Step 0 is the X shift unless dx is zero, in which case only Y remains
        if ((i_step == STEP_W'(0)) && (i_req.x != '0)) begin
          o_instruction = SHIFT_X;
          o_data        = {{(ADDR_W-POS_W){1'b0}}, i_req.x};
        end else begin
          o_instruction = SHIFT_Y;
          o_data        = {{(ADDR_W-POS_W){1'b0}}, i_req.y};
        end
      end
      KIND_HIDE: o_instruction = CLEAR_SPRITE;
      default:   o_instruction = SET_VISIBLE;
    endcase
  end

endmodule

// File: rtl/sprite_command_sequencer.sv
// Accepts one sprite request (define/move/hide/show), waits for vertical blanking,
// then issues its controller writes back to back and pulses Done one cycle later.
// Ports: Req* request handshake + fields, VBlank gate, SpriteSelect/Write/Instruction/
//        CmdData write port, Done completion pulse. One request in flight at a time.
module sprite_command_sequencer
  import gpu_sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SEL_W       = 4
)(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    VBlank,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic [KIND_W-1:0]       ReqKind,
  input  logic [SEL_W-1:0]        ReqSprite,
  input  logic [ADDR_W-1:0]       ReqAddress,
  input  logic signed [POS_W-1:0] ReqX,
  input  logic signed [POS_W-1:0] ReqY,
  input  logic [DIM_W-1:0]        ReqWidth,
  input  logic [DIM_W-1:0]        ReqHeight,
  output logic [SEL_W-1:0]        SpriteSelect,
  output logic                    Write,
  output logic [INSTR_W-1:0]      Instruction,
  output logic [ADDR_W-1:0]       CmdData,
  output logic                    Done
);

  if (SEL_W != $clog2(NUM_SPRITES)) begin : g_sel_w_check
    $error("SEL_W must equal clog2(NUM_SPRITES)");
  end

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  sprite_req_t        r_req;
  logic [SEL_W-1:0]   r_sprite;
  logic [STEP_W-1:0]  r_step;

  logic               r_write;
  logic               r_done;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_data;
  logic [SEL_W-1:0]   r_sel;

  logic               w_accept;
  logic               w_issue_now;
  logic               w_seq_end;
  logic [STEP_W-1:0]  w_count;
  sprite_req_t        w_req_in;
  logic [INSTR_W-1:0] w_enc_instr;
  logic [ADDR_W-1:0]  w_enc_data;

  logic               w_write_nxt;
  logic               w_done_nxt;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0]  w_data_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;

  // Ready is forced low while reset is held, not just after it is released
  assign ReqReady = (r_state == ST_IDLE) && !Reset;
  assign w_accept = ReqValid && ReqReady;

  assign w_req_in = '{kind: ReqKind, addr: ReqAddress, x: ReqX, y: ReqY,
                      width: ReqWidth, height: ReqHeight};

  assign w_count = write_count(r_req);

  // The cycle VBlank is first seen high behaves like an ISSUE cycle at step 0,
  // so the first write registers on that same edge.
  assign w_issue_now = (r_state == ST_ISSUE) ||
                       ((r_state == ST_WAIT_VBLANK) && VBlank);
  // All writes already emitted (or none needed): this edge raises Done
  assign w_seq_end   = w_issue_now && (r_step == w_count);

  sprite_cmd_encode u_encode (
    .i_req         (r_req),
    .i_step        (r_step),
    .o_instruction (w_enc_instr),
    .o_data        (w_enc_data)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_WAIT_VBLANK;
      end
      ST_WAIT_VBLANK: begin
        if (VBlank) w_state_nxt = w_seq_end ? ST_IDLE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_seq_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered write port, zeroed when not writing
  always_comb begin
    w_write_nxt = w_issue_now && !w_seq_end;
    w_done_nxt  = w_seq_end;
    w_instr_nxt = '0;
    w_data_nxt  = '0;
    w_sel_nxt   = '0;
    if (w_write_nxt) begin
      w_instr_nxt = w_enc_instr;
      w_data_nxt  = w_enc_data;
      w_sel_nxt   = r_sprite;
    end
  end

  // Request latch and step counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_req    <= '0;
      r_sprite <= '0;
      r_step   <= '0;
    end else if (w_accept) begin
      r_req    <= w_req_in;
      r_sprite <= ReqSprite;
      r_step   <= '0;
    end else if (w_write_nxt) begin
      r_step   <= r_step + STEP_W'(1);
    end
  end

  // Registered write port; async reset drops Write immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_instr <= '0;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      r_write <= w_write_nxt;
      r_done  <= w_done_nxt;
      r_instr <= w_instr_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign Write        = r_write;
  assign Done         = r_done;
  assign Instruction  = r_instr;
  assign CmdData      = r_data;
  assign SpriteSelect = r_sel;

endmodule

// File: doc/sprite_command_sequencer.md
Name: sprite_command_sequencer

Overview:
- Initiator for the per-sprite command port (Write/Instruction/Input) of the GPU sprite controllers.
- Accepts one high-level sprite request per handshake: define, move, hide or show.
- Expands each request into the ordered single-cycle instruction writes the sprite controllers decode.
- Issues writes only after vertical blanking begins, so a sprite never changes mid-frame.

Parameters:
- NUM_SPRITES, 16, number of sprite controllers addressed.
- SEL_W, 4, width of the sprite select; must equal clog2(NUM_SPRITES).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- VBlank  in  1  high during vertical blanking; synchronous to Clk.
- ReqValid  in  1  request present.
- ReqReady  out  1  sequencer can accept a request.
- ReqKind  in  2  0 = define, 1 = move, 2 = hide, 3 = show.
- ReqSprite  in  SEL_W  target sprite index.
- ReqAddress  in  23  sprite memory base address (define only).
- ReqX  in  11  signed; x position for define, x delta for move.
- ReqY  in  11  signed; y position for define, y delta for move.
- ReqWidth  in  10  width in pixels (define only).
- ReqHeight  in  10  height in pixels (define only).
- SpriteSelect  out  SEL_W  index of the controller targeted by Write.
- Write  out  1  one-cycle write strobe to the selected controller.
- Instruction  out  4  command code: 1 set sprite, 2 set X, 3 set Y, 4 width, 5 height, 6 shift X, 7 shift Y, 8 clear, 9 visible.
- CmdData  out  23  command payload, driven to the controller's Input.
- Done  out  1  one-cycle pulse after the last write of a request.

Behaviour:
- Reset values: Write=0, Instruction=0, CmdData=0, SpriteSelect=0, Done=0, ReqReady=0 while Reset is high. State returns to IDLE.
- States:
  - IDLE: ReqReady=1. On ReqValid&&ReqReady, latch all Req* fields and go to WAIT_VBLANK.
  - WAIT_VBLANK: ReqReady=0. When VBlank=1, go to ISSUE. The first write occurs in the same cycle VBlank is sampled high.
  - ISSUE: one write per cycle, back to back, with no gaps. After the final write, go to IDLE and assert Done in the next cycle.
- Write sequences by kind, in order:
  - Define: 4 (CmdData = zero-extended ReqWidth), 5 (ReqHeight), 2 (ReqX, sign bits in [10:0], [22:11]=0), 3 (ReqY, same), 1 (ReqAddress). Set-sprite goes last so the sprite becomes visible only with final geometry. Total 5 writes.
  - Move: 6 with CmdData[10:0]=ReqX, then 7 with ReqY. A zero delta skips its write. If both deltas are zero, issue no writes and still pulse Done.
  - Hide: single write with instruction 8, CmdData=0.
  - Show: single write with instruction 9, CmdData=0.
- Latency, VBlank already high: accepted at edge n, first Write at n+1, define's last write at n+5, Done at n+6, ReqReady high at n+6.
- Signal validity:
  - SpriteSelect holds the latched index throughout ISSUE.
  - Instruction, CmdData and SpriteSelect are meaningful only while Write=1 and are driven 0 otherwise.
- VBlank deasserts mid-ISSUE: the sequence completes atomically. VBlank is checked only at the WAIT_VBLANK→ISSUE transition.
- Request fields changing after acceptance have no effect.
- ReqAddress=0 on define is issued unchanged. The controller treats address 0 as a null sprite, and the sequencer does not filter it.
- Reset asserted mid-sequence: the remaining writes are abandoned, Write drops immediately (asynchronously), and no Done is pulsed.
- A request is never accepted in the same cycle Done pulses. ReqReady goes high at the Done cycle, so the next acceptance is at the earliest edge after Done.
- No internal queue: one request in flight.

Decomposition:
- Shared package gpu_sprite_pkg holds:
  - instruction code constants (SET_SPRITE=1 … SET_VISIBLE=9);
  - request kind constants (KIND_DEFINE, KIND_MOVE, KIND_HIDE, KIND_SHOW);
  - widths (ADDR_W=23, POS_W=11, DIM_W=10).
- The sprite controller uses the same instruction constants.
- The step-to-(Instruction, CmdData) mapping is a natural combinational sub-module, sprite_cmd_encode: inputs are latched kind, step index and latched fields; output is the instruction/payload pair.

Test Plan:
- Define sprite 3 (addr 0x001000, X=100, Y=-5, W=32, H=16) with VBlank=1 → five writes on consecutive cycles, SpriteSelect=3:
  - 4/0x000020, 5/0x000010, 2/0x000064, 3/0x0007FB, 1/0x001000;
  - Done one cycle after the last write.
- Move sprite 7 with dx=+4, dy=0 → single write 6/0x000004, no instruction 7, Done next cycle. Repeat with dx=0, dy=0 → zero writes, Done pulses once.
- Hide request accepted while VBlank=0 for 20 cycles, then VBlank rises → no Write during the wait; exactly one write 8/0 in the cycle VBlank is sampled high.
- Define accepted, VBlank drops after the second write → remaining three writes still issue on consecutive cycles.
- Reset pulsed during the third write of a define → Write=0 immediately, all outputs 0, no Done. After release, ReqReady=1 and a show request yields write 9 correctly.
- ReqValid held high across back-to-back requests, with Req* fields changed on cycles after acceptance → each request's writes use its accepted values, and requests never overlap.
